bus_arbiter4: RTL and testbench
===============================

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles a single grant may be held (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 req  input  4  request lines; bit i is requester i, level-sensitive.
REQ-005 done  input  1  transaction-complete pulse from the current grant holder.
REQ-006 grant  output  4  one-hot grant (all-zero when idle), registered.
REQ-007 select  output  2  binary index of the granted requester, driving the select input of the shared mux4to1, registered.
REQ-008 busy  output  1  high while any grant bit is high.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL implement two states: IDLE and BUSY.
REQ-011 The block SHALL hold a 2-bit round-robin pointer ptr naming the highest-priority requester.
REQ-012 IDLE, req != 0: the block SHALL select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE, req != 0 (cont.): at the next edge the block SHALL set the corresponding grant bit, load select with that index and enter BUSY, giving 1-cycle latency from req to grant.
REQ-014 IDLE, req == 0: the block SHALL keep grant = 0 and hold select at its last value.
REQ-015 done asserted in IDLE SHALL be ignored.
REQ-016 BUSY: the block SHALL hold grant and select constant.
REQ-017 BUSY: an 8-bit hold counter SHALL clear on entry to BUSY and increment by 1 each BUSY cycle.
REQ-018 BUSY release: the block SHALL leave BUSY at the edge where done=1, or the granted req bit is 0, or hold counter == MAX_HOLD-1.
REQ-019 On release the block SHALL clear grant, set ptr to (select+1) mod 4 and enter IDLE.
REQ-020 The block SHALL always insert one idle cycle between consecutive grants; back-to-back grants without a zero-grant cycle are not permitted.
REQ-021 timeout SHALL be 1 for exactly the cycle after a release caused solely by the hold limit.
REQ-022 If done=1 or the granted req=0 coincides with the hold limit, the release SHALL count as normal and timeout SHALL remain 0.
REQ-023 Requests from non-granted requesters during BUSY SHALL NOT affect grant; they SHALL only be considered in the next IDLE cycle.
REQ-024 grant SHALL never have more than one bit set.
REQ-025 busy SHALL equal the OR of the grant bits.
REQ-026 select SHALL equal the index of the set grant bit whenever busy=1.
REQ-027 The hold counter SHALL saturate and never wrap while in BUSY.

Reset
REQ-028 At a clk edge with reset=1: grant=0, select=0, busy=0, timeout=0, ptr=0, hold counter=0, state=IDLE, regardless of req/done.
REQ-029 Reset asserted in BUSY SHALL drop the grant at that edge with no timeout pulse.
REQ-030 After reset deasserts, arbitration SHALL start from ptr=0.

Verification
REQ-031 Reset, then req=4'b1111 with done pulsed 2 cycles after each grant -> grants in order 0001, 0010, 0100, 1000, 0001; select=0,1,2,3,0; one zero-grant cycle between each.
REQ-032 req=4'b0100 only, done never asserted, MAX_HOLD=16 -> grant=0100 for exactly 16 cycles, then grant=0 with timeout=1 for one cycle, then regrant 0100.
REQ-033 Requester 1 granted; req[3] rises mid-grant; done=1 -> grant stays 0010 until release; next grant is 1000 even if req[0]=1.
REQ-034 Granted requester drops req with done=0 -> grant clears at the next edge, timeout=0, ptr advances past that requester.
REQ-035 done=1 on the same cycle the hold counter reaches MAX_HOLD-1 -> release with timeout=0.
REQ-036 reset=1 during BUSY with req=4'b1111 -> grant=0 at that edge; after reset deasserts, the first grant is 0001.

Source files
------------

// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter. A grant is held until done, until the request drops, or until the hold limit is reached.
// Every release is followed by one idle cycle before the next grant.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;

  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       at_limit;
  logic       normal_rel;

  // Scan the request lines starting at ptr and take the first one that is set.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign at_limit   = (hold_cnt == LIMIT);
  assign normal_rel = done || !req[select];
  assign busy       = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= 4'(1) << pick;
            select   <= pick;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (normal_rel || at_limit) begin
            grant   <= '0;
            ptr     <= select + 2'd1;
            state   <= IDLE;
            // The limit only reports a timeout when it alone ended the grant.
            timeout <= !normal_rel;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4. A cycle model checks every output after each edge, and literal checks pin the model to known sequences.
module tb_bus_arbiter4;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .select(select), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the arbiter. owner is -1 when no grant is active, otherwise it holds the granted index.
  int owner = -1;
  int m_ptr = 0;
  int m_sel = 0;
  int m_cnt = 0;
  bit m_to  = 0;
  bit m_ok  = 0;

  always @(posedge clk) begin
    if (reset) begin
      owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0; m_to = 0; m_ok = 1;
    end else if (m_ok) begin
      if (owner < 0) begin
        m_to = 0;
        for (int k = 0; k < 4; k++)
          if (owner < 0 && req[(m_ptr + k) % 4]) owner = (m_ptr + k) % 4;
        if (owner >= 0) begin m_sel = owner; m_cnt = 0; end
      end else begin
        bit normal, lim;
        normal = done || !req[owner];
        lim    = (m_cnt == MAX_HOLD - 1);
        if (normal || lim) begin
          m_to  = !normal;
          m_ptr = (owner + 1) % 4;
          owner = -1;
        end else begin
          m_to  = 0;
          m_cnt = m_cnt + 1;
        end
      end
    end
    #1;
    if (m_ok) begin
      chk("model_grant",   8'(grant),   (owner < 0) ? 8'h00 : 8'(1 << owner));
      chk("model_select",  8'(select),  8'(m_sel));
      chk("model_busy",    8'(busy),    8'(owner >= 0));
      chk("model_timeout", 8'(timeout), 8'(m_to));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; done = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'b0; done = 1'b0;

    // Reset state, then a round-robin sweep with all four requesting
    do_reset();
    chk("reset_grant",   8'(grant),   8'h00);
    chk("reset_select",  8'(select),  8'h00);
    chk("reset_busy",    8'(busy),    8'h00);
    chk("reset_timeout", 8'(timeout), 8'h00);
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant",  8'(grant),  8'(1 << (i % 4)));
      chk("rr_select", 8'(select), 8'(i % 4));
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("rr_gap", 8'(grant), 8'h00);
      tick();
    end

    // A requester that never finishes is held for MAX_HOLD cycles, then timed out
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("hold_grant", 8'(grant), 8'h04);
      chk("hold_to",    8'(timeout), 8'h00);
      tick();
    end
    chk("to_grant", 8'(grant),   8'h00);
    chk("to_pulse", 8'(timeout), 8'h01);
    tick();
    chk("to_regrant", 8'(grant),   8'h04);
    chk("to_clear",   8'(timeout), 8'h00);

    // A request that arrives mid-grant waits; the pointer then prefers 3 over 0
    do_reset();
    req = 4'b0010;
    tick();
    chk("mid_grant1", 8'(grant), 8'h02);
    req = 4'b1011;
    tick();
    chk("mid_hold", 8'(grant), 8'h02);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("mid_rel", 8'(grant), 8'h00);
    tick();
    chk("mid_next", 8'(grant), 8'h08);

    // The holder drops its request, so the grant ends with no timeout
    do_reset();
    req = 4'b0001;
    tick();
    chk("drop_grant", 8'(grant), 8'h01);
    req = 4'b0000;
    tick();
    chk("drop_rel", 8'(grant),   8'h00);
    chk("drop_to",  8'(timeout), 8'h00);
    done = 1'b1;
    tick(2);
    chk("idle_done_ignored", 8'(grant), 8'h00);
    done = 1'b0;
    req = 4'b0011;
    tick();
    chk("drop_ptr_adv", 8'(grant), 8'h02);

    // done arrives in the same cycle as the hold limit
    do_reset();
    req = 4'b0100;
    tick(MAX_HOLD);
    chk("lim_still", 8'(grant), 8'h04);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("lim_rel",  8'(grant),   8'h00);
    chk("lim_noto", 8'(timeout), 8'h00);

    // Reset while busy with the pointer away from zero
    do_reset();
    req = 4'b1111;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("rst_busy_grant", 8'(grant), 8'h02);
    reset = 1'b1;
    tick();
    chk("rst_drop",  8'(grant),   8'h00);
    chk("rst_noto",  8'(timeout), 8'h00);
    reset = 1'b0;
    tick();
    chk("rst_first", 8'(grant), 8'h01);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
